serial_paralelo_phy: RTL and testbench
======================================

# serial_paralelo_phy

Receive-side deserializer of the PHY link. It consumes the 1-bit serial stream produced by the transmit side at the 8f rate and finds byte alignment on the COM symbol. It declares the link active after a run of consecutive COM bytes. It then delivers 8-bit words with a valid flag to the receive byte-unstriping stage, which splits them back into lanes 0/1.

## Interface
Parameters:
- COM_SYM, default 8'hBC: comma/idle symbol, used for alignment and marks "no valid data".
- ALIGN_CNT, default 4: consecutive aligned COM bytes required to enter ACTIVE (legal range 1..15).

Ports (single clock; reset is synchronous and active-high):
- clk_8f  input  1: bit clock; all state updates on its rising edge.
- reset  input  1: synchronous, active-high; sampled on posedge clk_8f.
- data_in  input  1: serial bit, MSB of each byte first.
- data_out  output  8: last received non-COM byte.
- valid_out  output  1: 1 while data_out holds a data byte received in ACTIVE.
- byte_stb  output  1: one-cycle pulse on each byte boundary while active.
- active  output  1: link aligned and locked.
- byte_count  output  8: present only with DESER_STATS_EN (see Configuration).

## Operation
- Shift register: sr <= {sr[6:0], data_in} every cycle. The candidate byte is cand = {sr[6:0], data_in}.
- States:
  - HUNT: no byte alignment. Each cycle, test cand == COM_SYM. On a match, go to COUNT with com_cnt = 1 and bit_cnt = 0.
  - COUNT: byte-aligned. bit_cnt increments each cycle and wraps at 7. The boundary cycle is bit_cnt == 7; at it, cand is the complete byte.
    - cand == COM_SYM: com_cnt++. If com_cnt + 1 == ALIGN_CNT, go to ACTIVE.
    - cand != COM_SYM: go to HUNT and clear com_cnt.
  - ALIGN_CNT == 1: the HUNT match goes directly to ACTIVE.
  - ACTIVE: bit_cnt keeps counting. On each boundary, byte_stb = 1 for that one cycle.
    - cand == COM_SYM: valid_out <= 0; data_out holds its previous value.
    - cand != COM_SYM: data_out <= cand, valid_out <= 1.
    - data_out and valid_out are held until the next boundary.
- ACTIVE is sticky. It is left only by reset. Any byte value, including repeated COM, is legal in ACTIVE.
- `active` = (state == ACTIVE), registered.
- In HUNT and COUNT:
  - valid_out = 0 and byte_stb = 0.
  - data_out holds its value (0 after reset).

## Timing
- Reset values:
  - data_out = 8'h00, valid_out = 0, byte_stb = 0, active = 0, byte_count = 0.
  - state = HUNT, sr = 0, bit_cnt = 0, com_cnt = 0.
- Reset asserted at edge k: all of the above hold after edge k, including mid-byte and in ACTIVE. The partial byte is discarded. Hunting restarts from the first bit sampled at the first edge with reset low.
- Latency: the last (LSB) bit of a byte is sampled at edge k. data_out, valid_out and byte_stb update at that same edge k, so they are visible in the cycle after k. This is one registered stage.
- Boundary spacing: in ACTIVE, byte_stb pulses exactly every 8 cycles and is never wider than 1 cycle.
- Entry into ACTIVE: `active` rises at the edge that samples the LSB of the ALIGN_CNT-th consecutive COM. The first byte_stb comes 8 cycles later.
- COUNT fallback on non-COM: the next edge is in HUNT. Bits of the rejected byte are still in sr, so a COM overlapping that byte can be re-detected one cycle later.
- There is no backpressure. The consumer must sample data_out/valid_out when byte_stb = 1.

## Configuration
- Macro DESER_STATS_EN.
  - Defined: adds output byte_count[7:0]. It increments by 1 on each boundary in ACTIVE where cand != COM_SYM, saturates at 8'hFF, and clears only on reset. It updates at the same edge as data_out.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Lock and deliver: after reset, send BC,BC,BC,BC,A4,32 MSB-first.
  - active rises at the LSB of the 4th BC.
  - Next boundary: byte_stb = 1, data_out = A4, valid_out = 1.
  - Then data_out = 32, valid_out = 1.
- Misaligned lock: send 3 junk bits 101, then BC x4, then FF. Alignment is found and data_out = FF, valid_out = 1.
- Interrupted run: send BC,BC,BC,55,BC,BC,BC,BC,EE.
  - active stays 0 through the 55 and the following bytes until the 4th of the second BC run.
  - After lock: data_out = EE, valid_out = 1.
- COM inside ACTIVE: while locked, send DD,BC,CC.
  - DD: data_out = DD, valid_out = 1.
  - BC: valid_out = 0, data_out stays DD, byte_stb still pulses.
  - CC: data_out = CC, valid_out = 1.
- Reset mid-byte: assert reset for 1 cycle after 3 bits of a data byte in ACTIVE.
  - Next cycle: all outputs 0 and active = 0.
  - Relock requires 4 fresh BC.
- Stats (DESER_STATS_EN defined): send 300 non-COM bytes after lock, with BC interleaved. byte_count = 8'hFF and does not wrap; the BC bytes do not count.

Source files
------------

// File: rtl/serial_paralelo_phy.sv
// Receive-side deserializer: aligns on the COM symbol, locks after a run of COM bytes,
// then presents bytes to the unstriping stage. Optional byte_count via DESER_STATS_EN.
module serial_paralelo_phy #(
    parameter logic [7:0]  COM_SYM   = 8'hBC,
    parameter int unsigned ALIGN_CNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_stb,
`ifdef DESER_STATS_EN
    output logic [7:0] byte_count,
`endif
    output logic       active
);

    typedef enum logic [1:0] {
        StHunt,
        StCount,
        StActive
    } state_e;

    localparam logic [3:0] AlignCnt = 4'(ALIGN_CNT);

    state_e     state_q, state_d;
    logic [6:0] sr_q;
    logic [7:0] cand;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       stb_q, stb_d;
    logic       is_com;
    logic       boundary;

    // Only the last seven bits are kept; the eighth is the bit arriving this cycle.
    assign cand     = {sr_q, data_in};
    assign is_com   = (cand == COM_SYM);
    assign boundary = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        stb_d     = 1'b0;
        unique case (state_q)
            StHunt: begin
                bit_cnt_d = 3'd0;
                valid_d   = 1'b0;
                if (is_com) begin
                    com_cnt_d = 4'd1;
                    state_d   = (AlignCnt == 4'd1) ? StActive : StCount;
                end
            end
            StCount: begin
                valid_d = 1'b0;
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_q + 4'd1 == AlignCnt) begin
                            state_d = StActive;
                        end
                    end else begin
                        // A COM overlapping the rejected byte can still be found next cycle.
                        state_d   = StHunt;
                        com_cnt_d = 4'd0;
                    end
                end
            end
            StActive: begin
                if (boundary) begin
                    stb_d = 1'b1;
                    if (is_com) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = cand;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StHunt;
            end
        endcase
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_q   <= StHunt;
            sr_q      <= 7'd0;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= cand[6:0];
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            stb_q     <= stb_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign byte_stb  = stb_q;
    assign active    = (state_q == StActive);

`ifdef DESER_STATS_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == StActive && boundary && !is_com && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign byte_count = count_q;
`endif

endmodule

// File: tb/tb_serial_paralelo_phy.sv
// Scoreboard bench for serial_paralelo_phy: a byte-level model predicts lock and delivered
// bytes; a monitor checks active/byte_stb each cycle and the byte on every strobe.
module tb_serial_paralelo_phy;

    localparam logic [7:0] COM = 8'hBC;
    localparam int ALIGN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_stb;
    logic       active;
`ifdef DESER_STATS_EN
    logic [7:0] byte_count;
`endif

    serial_paralelo_phy #(
        .COM_SYM  (COM),
        .ALIGN_CNT(ALIGN)
    ) dut (
        .clk_8f    (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .byte_stb  (byte_stb),
`ifdef DESER_STATS_EN
        .byte_count(byte_count),
`endif
        .active    (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic act;
        logic stb;
    } cyc_exp_t;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic [7:0] c;
    } byte_exp_t;

    cyc_exp_t  cyc_q[$];
    byte_exp_t byte_q[$];
    cyc_exp_t  ce;
    byte_exp_t be;

    int total = 0;
    int bad = 0;

    // Reference model: tracks position in the bit stream and where the next byte ends.
    logic [7:0] m_win;
    int         m_run;
    bit         m_hunt;
    bit         m_act;
    int         m_next;
    int         m_n;
    logic [7:0] m_last;
    int         m_cnt;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_win  = 8'h00;
        m_run  = 0;
        m_hunt = 1;
        m_act  = 0;
        m_next = 0;
        m_n    = 0;
        m_last = 8'h00;
        m_cnt  = 0;
        cyc_q.delete();
        byte_q.delete();
    endtask

    task automatic model_bit(input logic b);
        bit stb;
        byte_exp_t e;
        stb   = 0;
        m_win = {m_win[6:0], b};
        if (m_act) begin
            if (m_n == m_next) begin
                stb = 1;
                if (m_win != COM) begin
                    m_last = m_win;
                    if (m_cnt < 255) m_cnt++;
                end
                e.d = m_last;
                e.v = (m_win != COM);
                e.c = 8'(m_cnt);
                byte_q.push_back(e);
                m_next += 8;
            end
        end else if (m_hunt) begin
            if (m_win == COM) begin
                m_run  = 1;
                m_hunt = 0;
                m_next = m_n + 8;
                if (m_run == ALIGN) m_act = 1;
            end
        end else if (m_n == m_next) begin
            if (m_win == COM) begin
                m_run++;
                m_next += 8;
                if (m_run == ALIGN) m_act = 1;
            end else begin
                m_hunt = 1;
                m_run  = 0;
            end
        end
        m_n++;
        cyc_q.push_back('{act: m_act, stb: stb});
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic send_bit(input logic b);
        data_in = b;
        model_bit(b);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_valid_out", {7'd0, valid_out}, 8'h00);
        chk("rst_byte_stb", {7'd0, byte_stb}, 8'h00);
        chk("rst_active", {7'd0, active}, 8'h00);
`ifdef DESER_STATS_EN
        chk("rst_byte_count", byte_count, 8'h00);
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_lock();
        for (int i = 0; i < ALIGN; i++) send_byte(COM);
    endtask

    function automatic logic [7:0] rand_data();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == COM) b = 8'h00;
        return b;
    endfunction

    // Monitor: per-cycle lock/strobe check plus scoreboard pop on every strobe.
    always @(posedge clk) begin
        #2;
        if (cyc_q.size() > 0) begin
            ce = cyc_q.pop_front();
            chk("active", {7'd0, active}, {7'd0, ce.act});
            chk("byte_stb", {7'd0, byte_stb}, {7'd0, ce.stb});
        end
        if (byte_stb && !reset) begin
            if (byte_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL strobe_no_expected: got byte_stb 1 expected 0 at %0t", $time);
            end else begin
                be = byte_q.pop_front();
                chk("data_out", data_out, be.d);
                chk("valid_out", {7'd0, valid_out}, {7'd0, be.v});
`ifdef DESER_STATS_EN
                chk("byte_count", byte_count, be.c);
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Lock and deliver.
        do_reset();
        send_lock();
        send_byte(8'hA4);
        send_byte(8'h32);
        send_byte(COM);

        // Misaligned lock.
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_lock();
        send_byte(8'hFF);
        send_byte(COM);

        // Interrupted run, then COM inside ACTIVE.
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(COM);
        send_byte(8'h55);
        send_lock();
        send_byte(8'hEE);
        send_byte(8'hDD);
        send_byte(COM);
        send_byte(8'hCC);
        send_byte(COM);

        // Reset mid-byte in ACTIVE, then relock needing four fresh COM.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(COM);
        send_byte(8'h3C);
        send_lock();
        send_byte(8'h81);
        send_byte(COM);

        // Randomized runs: junk bits, lock, mixed data and COM.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < int'($urandom_range(0, 12)); i++) send_bit(1'($urandom));
            send_lock();
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 9) < 3) send_byte(COM);
                else send_byte(8'($urandom_range(0, 255)));
            end
            send_byte(COM);
        end

`ifdef DESER_STATS_EN
        // Saturation: 300 data bytes with COM interleaved.
        do_reset();
        send_lock();
        for (int i = 0; i < 300; i++) begin
            send_byte(rand_data());
            if (i % 5 == 0) send_byte(COM);
        end
        send_byte(COM);
        chk("count_saturated", byte_count, 8'hFF);
`endif

        repeat (3) send_bit(1'b0);
        chk("scoreboard_drained", 8'(byte_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
